spi_flash_responder: RTL and testbench
======================================

// Module: spi_flash_responder
// PURPOSE
//  Synthesizable SPI-flash responder (mode 0) answering the READ (0x03) stream the VGA SPI-ROM core issues.
//  Oversamples cs_n/sclk/mosi on the system clock.
//  Serves bytes from an external byte memory via a registered read port.
//  Stands in for the physical flash chip on FPGA builds and in benches.
// PARAMETERS
//  ADDR_BITS   18     memory depth = 2**ADDR_BITS bytes; upper flash address bits ignored (mirror)
//  READ_OP     8'h03  only opcode served; any other opcode -> ignored until cs_n rises
// PORTS
//  clk          in   1          system clock; must be >= 8x spi_sclk frequency
//  rst_n        in   1          synchronous, active-low reset
//  spi_cs_n     in   1          chip select, active low (asynchronous to clk)
//  spi_sclk     in   1          SPI clock, idles low (mode 0)
//  spi_mosi     in   1          command/address from initiator, MSB first
//  spi_miso     out  1          read data, MSB first
//  spi_miso_oe  out  1          1 while in DATA state (pad tri-state enable)
//  mem_addr     out  ADDR_BITS  byte address to memory
//  mem_data     in   8          memory byte; valid 1 clk after mem_addr changes
//  busy         out  1          1 whenever synchronized cs_n is low
//  bad_cmd      out  1          sticky: non-READ opcode received since reset
// BEHAVIOUR
//  Reset values: spi_miso=0, spi_miso_oe=0, mem_addr=0, busy=0, bad_cmd=0, state=IDLE, counters=0.
//  Inputs pass 2-flop synchronizers.
//  Edge pulses come from sync stage vs. a third flop: sclk_rise, sclk_fall, cs_fall, cs_rise.
//  Edge latency: 3 clk from pin to pulse.
//  States:
//   IDLE: cs_fall -> CMD; bit_cnt=0.
//   CMD: on sclk_rise shift mosi into cmd_sr; after 8th bit:
//    ==READ_OP -> ADDR.
//    else -> IGNORE and set bad_cmd.
//   ADDR: on sclk_rise shift 24 bits into addr_sr. After 24th bit:
//    mem_addr <= addr_sr[ADDR_BITS-1:0].
//    go to DATA with bit_idx=7, fetch pending.
//   DATA: mem_data captured into tx_byte 2 clk after mem_addr update (before next sclk_fall, guaranteed by 8x ratio).
//    On each sclk_fall drive spi_miso <= tx_byte[bit_idx] and decrement bit_idx.
//    The first sclk_fall after the 32nd rising edge drives bit 7.
//    When bit 0 is driven: mem_addr <= mem_addr+1 (wraps 2**ADDR_BITS-1 -> 0), prefetch next byte, bit_idx=7.
//    Stream continues indefinitely while cs_n low.
//   IGNORE: miso_oe=0, no memory access.
//  cs_rise in any state (incl. mid-byte, mid-address) -> IDLE within 1 clk after pulse.
//   Clears shift regs and counters; spi_miso_oe=0, spi_miso=0; mem_addr holds.
//  cs_fall and cs_rise never in same cycle (synchronizer). sclk edges while cs high are ignored.
//  sclk_rise and sclk_fall cannot coincide; a sclk edge coincident with cs_rise is discarded.
//  Address arithmetic is ADDR_BITS wide, unsigned, modulo 2**ADDR_BITS.
//  rst_n low mid-transaction -> reset values next clk.
//   After rst_n release, responder waits for a fresh cs_fall (cs low at release stays ignored).
// STRUCTURE
//  helpers.v: `SPI_OP_READ 8'h03, state encodings `SPIR_IDLE/CMD/ADDR/DATA/IGNORE.
//  Sub-module spi_sync_edge (2-flop sync + edge detect, instanced for cs_n, sclk, mosi).
//  Top holds FSM, shifters, address counter, tx byte.
// TESTING
//  1. Memory byte n = n[7:0]. cs low, send 03 00 00 10, clock 32 more sclk.
//     -> MISO bytes 10 11 12 13; miso_oe high from first data fall edge.
//  2. READ at 0x03FFFE (ADDR_BITS=18), 4 bytes.
//     -> bytes from mem 0x3FFFE,0x3FFFF,0x00000,0x00001 (wrap).
//  3. Send opcode 0x9F then 24 sclk.
//     -> miso_oe stays 0, bad_cmd=1 and sticky; following READ still works.
//  4. Raise cs_n after 13 address bits, then new READ 00 00 05.
//     -> first byte is 05; no corruption from partial frame.
//  5. rst_n low 1 clk during DATA byte 2.
//     -> all outputs at reset values; remainder of frame ignored; next frame served correctly.
//  6. clk = exactly 8x sclk, random READ addresses x50 frames.
//     -> every bit matches memory model, first bit valid before its sclk rise.

Source files
------------

// File: rtl/spi_flash_responder_pkg.sv
// spi_flash_responder_pkg -- opcode, FSM states and counter limits shared by the responder.
// Revision 1.0
`default_nettype none

package spi_flash_responder_pkg;

  localparam int          DEFAULT_ADDR_BITS = 18;
  localparam logic [7:0]  SPI_OP_READ       = 8'h03;

  localparam logic [4:0]  CMD_LAST_BIT      = 5'd7;
  localparam logic [4:0]  ADDR_LAST_BIT     = 5'd23;
  localparam logic [1:0]  FETCH_WAIT        = 2'd2;
  localparam logic [1:0]  SETTLE_DONE       = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_IGNORE = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/spi_flash_responder_if.sv
// spi_flash_responder_if -- SPI pins, memory read port and status flags of the responder.
// Revision 1.0
`default_nettype none

interface spi_flash_responder_if
  import spi_flash_responder_pkg::*;
#(
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS
);

  logic                 spi_cs_n;
  logic                 spi_sclk;
  logic                 spi_mosi;
  logic                 spi_miso;
  logic                 spi_miso_oe;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [7:0]           mem_data;
  logic                 busy;
  logic                 bad_cmd;

  modport slave (
    input  spi_cs_n, spi_sclk, spi_mosi, mem_data,
    output spi_miso, spi_miso_oe, mem_addr, busy, bad_cmd
  );

  modport master (
    output spi_cs_n, spi_sclk, spi_mosi, mem_data,
    input  spi_miso, spi_miso_oe, mem_addr, busy, bad_cmd
  );

endinterface

`default_nettype wire

// File: rtl/spi_flash_responder_sync_edge.sv
// spi_flash_responder_sync_edge -- 2-flop synchronizer plus a third flop for edge pulses.
// Revision 1.0
`default_nettype none

module spi_flash_responder_sync_edge
  import spi_flash_responder_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      sync <= RESET_VAL;
      prev <= RESET_VAL;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

`default_nettype wire

// File: rtl/spi_flash_responder.sv
// spi_flash_responder -- mode-0 SPI flash READ responder serving bytes from an external memory.
// Revision 1.0
`default_nettype none

module spi_flash_responder
  import spi_flash_responder_pkg::*;
#(
  parameter int         ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter logic [7:0] READ_OP   = SPI_OP_READ
) (
  input  logic                   clk,
  input  logic                   rst_n,
  spi_flash_responder_if.slave   bus
);

  logic cs_n_s, cs_rise, cs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_edges;

  spi_flash_responder_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(bus.spi_cs_n),
    .level(cs_n_s), .rise(cs_rise), .fall(cs_fall)
  );
  spi_flash_responder_sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(bus.spi_sclk),
    .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_flash_responder_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(bus.spi_mosi),
    .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );
  assign unused_edges = ^{sclk_s, mosi_rise, mosi_fall};

  state_t                 state, state_nxt;
  logic [1:0]             settle_cnt;
  logic [4:0]             bit_cnt;
  logic [6:0]             cmd_sr;
  logic [ADDR_BITS-2:0]   addr_sr;
  logic [2:0]             bit_idx;
  logic [1:0]             fetch_cnt;
  logic [7:0]             tx_byte;
  logic                   miso, miso_oe, bad_cmd;
  logic [ADDR_BITS-1:0]   mem_addr;

  logic [7:0]             cmd_next;
  logic [ADDR_BITS-1:0]   addr_next;
  logic                   frame_start;

  assign cmd_next  = {cmd_sr, mosi_s};
  assign addr_next = {addr_sr, mosi_s};
  // The cs fall that the sync pipeline produces while refilling after reset is not a real frame
  assign frame_start = cs_fall & (settle_cnt == SETTLE_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cs_rise) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (frame_start) state_nxt = ST_CMD;
        ST_CMD:  if (sclk_rise && bit_cnt == CMD_LAST_BIT)
                   state_nxt = (cmd_next == READ_OP) ? ST_ADDR : ST_IGNORE;
        ST_ADDR: if (sclk_rise && bit_cnt == ADDR_LAST_BIT) state_nxt = ST_DATA;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      bit_cnt    <= '0;
      cmd_sr     <= '0;
      addr_sr    <= '0;
      bit_idx    <= '0;
      fetch_cnt  <= '0;
      tx_byte    <= '0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      mem_addr   <= '0;
      bad_cmd    <= 1'b0;
    end else begin
      if (settle_cnt != SETTLE_DONE) settle_cnt <= settle_cnt + 2'd1;
      if (cs_rise) begin
        bit_cnt   <= '0;
        cmd_sr    <= '0;
        addr_sr   <= '0;
        bit_idx   <= '0;
        fetch_cnt <= '0;
        tx_byte   <= '0;
        miso      <= 1'b0;
        miso_oe   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (frame_start) begin
            bit_cnt <= '0;
            cmd_sr  <= '0;
            addr_sr <= '0;
          end
          ST_CMD: if (sclk_rise) begin
            cmd_sr <= cmd_next[6:0];
            if (bit_cnt == CMD_LAST_BIT) begin
              bit_cnt <= '0;
              if (cmd_next != READ_OP) bad_cmd <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          ST_ADDR: if (sclk_rise) begin
            addr_sr <= addr_next[ADDR_BITS-2:0];
            if (bit_cnt == ADDR_LAST_BIT) begin
              bit_cnt   <= '0;
              mem_addr  <= addr_next;
              bit_idx   <= 3'd7;
              fetch_cnt <= FETCH_WAIT;
              miso_oe   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          ST_DATA: begin
            // Memory answers one clk after mem_addr moves; capture on the clk after that
            if (fetch_cnt != 2'd0) begin
              fetch_cnt <= fetch_cnt - 2'd1;
              if (fetch_cnt == 2'd1) tx_byte <= bus.mem_data;
            end
            if (sclk_fall) begin
              miso <= tx_byte[bit_idx];
              if (bit_idx == 3'd0) begin
                bit_idx   <= 3'd7;
                mem_addr  <= mem_addr + ADDR_BITS'(1);
                fetch_cnt <= FETCH_WAIT;
              end else begin
                bit_idx <= bit_idx - 3'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.spi_miso    = miso;
  assign bus.spi_miso_oe = miso_oe;
  assign bus.mem_addr    = mem_addr;
  assign bus.busy        = ~cs_n_s;
  assign bus.bad_cmd     = bad_cmd;

endmodule

`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder -- SPI master driving READ frames, checked against a memory-based model.
// Revision 1.0
`default_nettype none

module tb_spi_flash_responder;
  import spi_flash_responder_pkg::*;

  localparam int AB = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_flash_responder_if #(.ADDR_BITS(AB)) bus ();

  spi_flash_responder #(.ADDR_BITS(AB), .READ_OP(8'h03)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic [7:0] mem [0:(1<<AB)-1];
  always @(posedge clk) bus.mem_data <= mem[bus.mem_addr];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: after 32 command/address rises, rise n returns bit (7 - d%8) of mem[(addr + d/8) mod 2**AB], d = n-32
  int          fid = 0;
  int          m_mode = 0;   // 0 READ, 1 bad opcode, 2 frame abandoned by reset
  logic [23:0] m_addr = '0;

  function automatic logic model_bit(input int n);
    int d;
    logic [AB-1:0] a;
    logic [7:0] b;
    d = n - 32;
    a = m_addr[AB-1:0] + AB'(d / 8);
    b = mem[a];
    return b[3'(7 - (d % 8))];
  endfunction

  int rn = 0;
  int seen_fid = -1;
  always @(posedge bus.spi_sclk) begin
    if (!bus.spi_cs_n) begin
      if (fid != seen_fid) begin
        rn = 0;
        seen_fid = fid;
      end
      if (m_mode == 0 && rn >= 32) begin
        check("miso_bit", {31'd0, bus.spi_miso}, {31'd0, model_bit(rn)});
        check("miso_oe_data", {31'd0, bus.spi_miso_oe}, 32'd1);
      end else if (m_mode == 2) begin
        check("dead_miso", {31'd0, bus.spi_miso}, 32'd0);
        check("dead_miso_oe", {31'd0, bus.spi_miso_oe}, 32'd0);
      end else begin
        check("miso_oe_off", {31'd0, bus.spi_miso_oe}, 32'd0);
      end
      rn++;
    end
  end

  logic [7:0] rx_q [$];

  task automatic check_reset_values(input string tag);
    check({tag, "_miso"},    {31'd0, bus.spi_miso},    32'd0);
    check({tag, "_miso_oe"}, {31'd0, bus.spi_miso_oe}, 32'd0);
    check({tag, "_busy"},    {31'd0, bus.busy},        32'd0);
    check({tag, "_bad_cmd"}, {31'd0, bus.bad_cmd},     32'd0);
    check({tag, "_mem_addr"}, 32'(bus.mem_addr),       32'd0);
  endtask

  task automatic spi_frame(input logic [7:0] cmd, input logic [23:0] addr,
                           input int nrise, input int rst_at, input int mode);
    logic [31:0] word;
    logic [7:0]  rxb;
    word = {cmd, addr};
    rxb = '0;
    rx_q.delete();
    m_addr = addr;
    m_mode = mode;
    fid++;
    @(posedge clk); #1 bus.spi_cs_n = 1'b0;
    repeat (8) @(posedge clk);
    #1 check("busy_in_frame", {31'd0, bus.busy}, 32'd1);
    for (int i = 0; i < nrise; i++) begin
      bus.spi_mosi = (i < 32) ? word[31-i] : 1'b0;
      repeat (4) @(posedge clk);
      #1 bus.spi_sclk = 1'b1;
      rxb = {rxb[6:0], bus.spi_miso};
      if (i >= 32 && ((i - 32) % 8) == 7) rx_q.push_back(rxb);
      if (i == rst_at) begin
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1 check_reset_values("midreset");
        rst_n = 1'b1;
        m_mode = 2;
      end
      repeat (4) @(posedge clk);
      #1 bus.spi_sclk = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1 bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    repeat (8) @(posedge clk);
    #1 check("busy_after_frame", {31'd0, bus.busy}, 32'd0);
    check("miso_oe_after_frame", {31'd0, bus.spi_miso_oe}, 32'd0);
    check("miso_after_frame", {31'd0, bus.spi_miso}, 32'd0);
  endtask

  task automatic expect_rx(input string tag, input int n, input logic [31:0] exp_word);
    check({tag, "_count"}, 32'(rx_q.size()), 32'(n));
    for (int k = 0; k < n; k++) begin
      if (k < rx_q.size()) check(tag, {24'd0, rx_q[k]}, {24'd0, exp_word[8*(n-1-k) +: 8]});
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.spi_cs_n = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    for (int i = 0; i < (1 << AB); i++) mem[i] = 8'(i);

    repeat (3) @(posedge clk);
    #1 check_reset_values("reset");
    rst_n = 1'b1;
    repeat (6) @(posedge clk);

    // Plain READ at 0x10
    spi_frame(8'h03, 24'h000010, 64, -1, 0);
    expect_rx("read_0x10", 4, 32'h10111213);

    // Wrap at the top of an 18-bit memory
    spi_frame(8'h03, 24'h03FFFE, 64, -1, 0);
    expect_rx("read_wrap", 4, 32'hFEFF0001);

    // Unsupported opcode, then a READ still works and bad_cmd stays set
    check("bad_cmd_before", {31'd0, bus.bad_cmd}, 32'd0);
    spi_frame(8'h9F, 24'h000000, 32, -1, 1);
    check("bad_cmd_set", {31'd0, bus.bad_cmd}, 32'd1);
    spi_frame(8'h03, 24'h000020, 48, -1, 0);
    expect_rx("read_after_bad", 2, 32'h00002021);
    check("bad_cmd_sticky", {31'd0, bus.bad_cmd}, 32'd1);

    // Frame cut after 13 address bits, then a fresh READ at 5
    spi_frame(8'h03, 24'h000000, 21, -1, 0);
    spi_frame(8'h03, 24'h000005, 40, -1, 0);
    expect_rx("read_after_abort", 1, 32'h00000005);

    // Reset pulse during the second data byte
    spi_frame(8'h03, 24'h000040, 64, 43, 0);
    check("reset_first_byte_count", 32'(rx_q.size() >= 1), 32'd1);
    if (rx_q.size() >= 1) check("reset_first_byte", {24'd0, rx_q[0]}, 32'h40);
    check("bad_cmd_cleared", {31'd0, bus.bad_cmd}, 32'd0);
    spi_frame(8'h03, 24'h000007, 48, -1, 0);
    expect_rx("read_after_reset", 2, 32'h00000708);

    // Random memory contents and random addresses, upper address bits mirrored
    for (int i = 0; i < (1 << AB); i++) mem[i] = 8'($urandom);
    for (int f = 0; f < 50; f++) begin
      spi_frame(8'h03, 24'($urandom), 48, -1, 0);
      check("random_byte_count", 32'(rx_q.size()), 32'd2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
